// File: rtl/cmp_pkg.sv
// Shared types and the MSB-first decision step for the serial comparator family.
// The step is kept as a function so other serial blocks reuse the same rule.
package cmp_pkg;

    typedef enum logic [1:0] {CMP_EQ, CMP_LT, CMP_GT} cmp_result_e;

    typedef enum logic [1:0] {ST_IDLE, ST_COMPARE, ST_HOLD} scmp_state_e;

    // Once a bit pair has differed, the decision is final.
    // Later, less significant bits cannot change it.
    function automatic cmp_result_e cmp_decide(input cmp_result_e d,
                                               input logic a,
                                               input logic b);
        if (d != CMP_EQ)
            return d;
        else if (a & ~b)
            return CMP_GT;
        else if (~a & b)
            return CMP_LT;
        else
            return CMP_EQ;
    endfunction

endpackage

// File: rtl/serial_cmp_cell.sv
// Combinational cell for one MSB-first compare step.
// Shared with the serial min/max blocks.
module serial_cmp_cell
    import cmp_pkg::*;
(
    input  cmp_result_e dec_in,
    input  logic        a_bit,
    input  logic        b_bit,
    output cmp_result_e dec_out
);

    assign dec_out = cmp_decide(dec_in, a_bit, b_bit);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator. Operands arrive MSB-first, one bit pair per beat.
// The result is held until it is consumed, and malformed frames raise frame_err.
module serial_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter  int WIDTH = 2,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_first,
    input  logic in_last,
    input  logic a_bit,
    input  logic b_bit,
    output logic out_valid,
    input  logic out_ready,
    output logic lower,
    output logic greater,
    output logic equal,
    output logic frame_err
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

    scmp_state_e      state, state_d;
    cmp_result_e      dec, dec_d, dec_step, dec_seed;
    logic [CNT_W-1:0] cnt, cnt_d, cnt_step;
    logic             err_d, err_q;
    logic             beat;

    assign beat = in_valid & in_ready;

    // A beat carrying in_first always starts a fresh decision and count.
    assign dec_seed = in_first ? CMP_EQ : dec;
    assign cnt_step = in_first ? CNT_W'(1) : cnt + CNT_W'(1);

    serial_cmp_cell u_cell (
        .dec_in  (dec_seed),
        .a_bit   (a_bit),
        .b_bit   (b_bit),
        .dec_out (dec_step)
    );

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned, which would infer a latch.
        state_d = state;
        dec_d   = dec;
        cnt_d   = cnt;
        err_d   = 1'b0;

        if (beat) begin
            if ((state == ST_IDLE) && !in_first) begin
                err_d = 1'b1;
            end else begin
                err_d = (state == ST_COMPARE) && in_first;
                dec_d = dec_step;
                cnt_d = cnt_step;
                // The frame must end exactly on its WIDTH-th beat.
                if (cnt_step == LAST_CNT) begin
                    if (in_last) begin
                        state_d = ST_HOLD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (in_last) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_COMPARE;
                end
            end
        end else if ((state == ST_HOLD) && out_ready) begin
            state_d = ST_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            dec   <= CMP_EQ;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_d;
            dec   <= dec_d;
            cnt   <= cnt_d;
            err_q <= err_d;
        end
    end

    assign in_ready  = rst_n & (state != ST_HOLD);
    assign out_valid = (state == ST_HOLD);
    assign lower     = out_valid & (dec == CMP_LT);
    assign greater   = out_valid & (dec == CMP_GT);
    assign equal     = out_valid & (dec == CMP_EQ);
    assign frame_err = err_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator at WIDTH 1, 2 and 8.
// Each instance gets its own in_valid so only the selected one sees beats.
module tb_serial_magnitude_comparator;

    typedef struct {
        int         w;
        logic [7:0] a;
        logic [7:0] b;
        logic       el;
        logic       eg;
        logic       ee;
        logic       gaps;
    } vec_t;

    logic clk, rst_n;
    logic in_valid, in_first, in_last, a_bit, b_bit, out_ready;
    int   sel_w;

    logic v1, v2, v8;
    logic rdy1, rdy2, rdy8, ov1, ov2, ov8;
    logic lo1, lo2, lo8, gt1, gt2, gt8, eq1, eq2, eq8, fe1, fe2, fe8;
    logic s_rdy, s_ov, s_lo, s_gt, s_eq, s_fe;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    assign v1 = in_valid & (sel_w == 1);
    assign v2 = in_valid & (sel_w == 2);
    assign v8 = in_valid & (sel_w == 8);

    serial_magnitude_comparator #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1),
        .in_first(in_first), .in_last(in_last), .a_bit(a_bit), .b_bit(b_bit),
        .out_valid(ov1), .out_ready(out_ready), .lower(lo1), .greater(gt1),
        .equal(eq1), .frame_err(fe1));

    serial_magnitude_comparator #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2),
        .in_first(in_first), .in_last(in_last), .a_bit(a_bit), .b_bit(b_bit),
        .out_valid(ov2), .out_ready(out_ready), .lower(lo2), .greater(gt2),
        .equal(eq2), .frame_err(fe2));

    serial_magnitude_comparator #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8),
        .in_first(in_first), .in_last(in_last), .a_bit(a_bit), .b_bit(b_bit),
        .out_valid(ov8), .out_ready(out_ready), .lower(lo8), .greater(gt8),
        .equal(eq8), .frame_err(fe8));

    always_comb begin
        case (sel_w)
            1:       {s_rdy, s_ov, s_lo, s_gt, s_eq, s_fe} = {rdy1, ov1, lo1, gt1, eq1, fe1};
            8:       {s_rdy, s_ov, s_lo, s_gt, s_eq, s_fe} = {rdy8, ov8, lo8, gt8, eq8, fe8};
            default: {s_rdy, s_ov, s_lo, s_gt, s_eq, s_fe} = {rdy2, ov2, lo2, gt2, eq2, fe2};
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string name, input logic ov, input logic lo,
                              input logic gt, input logic eq);
        check({name, " out_valid"}, s_ov, ov);
        check({name, " lower"},     s_lo, lo);
        check({name, " greater"},   s_gt, gt);
        check({name, " equal"},     s_eq, eq);
    endtask

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for exactly one clock edge.
    task automatic beat(input logic first, input logic last, input logic a, input logic b);
        in_valid = 1'b1;
        in_first = first;
        in_last  = last;
        a_bit    = a;
        b_bit    = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag   = $sformatf("vec%0d w%0d", idx, v.w);
        sel_w = v.w;
        for (int i = v.w - 1; i >= 0; i--) begin
            beat(i == v.w - 1, i == 0, v.a[i], v.b[i]);
            if (v.gaps && i > 0) begin
                wait_cycle();
                check({tag, " gap no result"}, s_ov, 1'b0);
            end
        end
        check_outs(tag, 1'b1, v.el, v.eg, v.ee);
        wait_cycle();
        check({tag, " cleared"}, s_ov, 1'b0);
        check({tag, " ready again"}, s_rdy, 1'b1);
    endtask

    task automatic add(input int w, input logic [7:0] a, input logic [7:0] b,
                       input logic el, input logic eg, input logic ee, input logic gaps);
        vec_t v;
        v.w = w; v.a = a; v.b = b; v.el = el; v.eg = eg; v.ee = ee; v.gaps = gaps;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        a_bit = 1'b0; b_bit = 1'b0; out_ready = 1'b1; sel_w = 2;

        //           w  a      b      lt gt eq gaps
        add(2, 8'h02, 8'h01, 0, 1, 0, 0);
        add(2, 8'h01, 8'h02, 1, 0, 0, 0);
        add(2, 8'h03, 8'h03, 0, 0, 1, 0);
        add(2, 8'h00, 8'h00, 0, 0, 1, 0);
        add(2, 8'h02, 8'h03, 1, 0, 0, 1);
        add(1, 8'h01, 8'h00, 0, 1, 0, 0);
        add(1, 8'h00, 8'h00, 0, 0, 1, 0);
        add(1, 8'h00, 8'h01, 1, 0, 0, 0);
        add(1, 8'h01, 8'h01, 0, 0, 1, 0);
        add(8, 8'h80, 8'h7F, 0, 1, 0, 0);
        add(8, 8'h80, 8'h7F, 0, 1, 0, 1);
        add(8, 8'h3C, 8'h3D, 1, 0, 0, 0);
        add(8, 8'hA5, 8'hA5, 0, 0, 1, 1);

        // Reset state
        #2;
        check("reset in_ready", s_rdy, 1'b0);
        check("reset frame_err", s_fe, 1'b0);
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        #11 rst_n = 1'b1;
        wait_cycle();
        check("post reset in_ready", s_rdy, 1'b1);

        foreach (vecs[i]) run_vec(i, vecs[i]);
        sel_w = 2;

        // Backpressure: result held for five cycles, then released
        out_ready = 1'b0;
        beat(1'b1, 1'b0, 1'b1, 1'b0);
        beat(1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check_outs($sformatf("hold%0d", k), 1'b1, 1'b0, 1'b1, 1'b0);
            check($sformatf("hold%0d in_ready", k), s_rdy, 1'b0);
            wait_cycle();
        end
        out_ready = 1'b1;
        check("release out_valid", s_ov, 1'b1);
        wait_cycle();
        check("after handshake out_valid", s_ov, 1'b0);
        check("after handshake in_ready", s_rdy, 1'b1);
        beat(1'b1, 1'b0, 1'b0, 1'b1);
        beat(1'b0, 1'b1, 1'b1, 1'b0);
        check_outs("post backpressure", 1'b1, 1'b1, 1'b0, 1'b0);
        wait_cycle();

        // Beat without in_first from IDLE
        beat(1'b0, 1'b0, 1'b1, 1'b0);
        check("no first err", s_fe, 1'b1);
        check("no first out_valid", s_ov, 1'b0);
        wait_cycle();
        check("no first err pulse", s_fe, 1'b0);

        // in_last on the first beat of a two-beat frame
        beat(1'b1, 1'b1, 1'b1, 1'b0);
        check("early last err", s_fe, 1'b1);
        check("early last out_valid", s_ov, 1'b0);
        wait_cycle();
        check("early last err pulse", s_fe, 1'b0);
        check("early last no result", s_ov, 1'b0);

        // Final beat missing in_last
        beat(1'b1, 1'b0, 1'b1, 1'b0);
        beat(1'b0, 1'b0, 1'b0, 1'b1);
        check("missing last err", s_fe, 1'b1);
        check("missing last out_valid", s_ov, 1'b0);
        wait_cycle();
        check("missing last no result", s_ov, 1'b0);

        // Second in_first restarts the frame: result comes from the new beats (A=01 B=10)
        beat(1'b1, 1'b0, 1'b1, 1'b0);
        beat(1'b1, 1'b0, 1'b0, 1'b1);
        check("restart err", s_fe, 1'b1);
        check("restart out_valid", s_ov, 1'b0);
        beat(1'b0, 1'b1, 1'b1, 1'b0);
        check("restart err cleared", s_fe, 1'b0);
        check_outs("restart", 1'b1, 1'b1, 1'b0, 1'b0);
        wait_cycle();

        // Reset mid-frame drops the partial frame
        beat(1'b1, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid reset in_ready", s_rdy, 1'b0);
        check("mid reset frame_err", s_fe, 1'b0);
        check_outs("mid reset", 1'b0, 1'b0, 1'b0, 1'b0);
        wait_cycle();
        check("mid reset in_ready held", s_rdy, 1'b0);
        #2 rst_n = 1'b1;
        wait_cycle();
        check("after reset in_ready", s_rdy, 1'b1);
        beat(1'b0, 1'b1, 1'b0, 1'b1);
        check("stale frame err", s_fe, 1'b1);
        check("stale frame no result", s_ov, 1'b0);
        wait_cycle();
        beat(1'b1, 1'b0, 1'b1, 1'b1);
        beat(1'b0, 1'b1, 1'b1, 1'b0);
        check_outs("after reset frame", 1'b1, 1'b0, 1'b1, 1'b0);
        wait_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
